pipelined_adder_tree: RTL and testbench

Registered, signed, N-input reduction tree with valid/ready flow control and a multi-beat accumulator. It is the pipelined successor to the combinational adder tree in the attention/MLP datapath. It reduces one N-wide vector per accepted beat and sums ACC_BEATS consecutive beats, so dot products longer than N close at full clock rate. Downstream softmax/requantisation stages consume `out_sum` through a valid/ready handshake.

---
 rtl/pipelined_adder_tree.sv | 129 ++++++++++++
 tb/tb_pipelined_adder_tree.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder_tree.sv
// Registered signed N-input reduction tree + ACC_BEATS accumulator; latency $clog2(N)+1, whole pipe stalls on out_valid && !out_ready.
// Optional ADDER_TREE_SAT_EN: clamp out_sum (and flag out_sat) when OW < full width, instead of wrapping.
module pipelined_adder_tree #(
    parameter int N         = 12,
    parameter int IW        = 15,
    parameter int ACC_BEATS = 4,
    parameter int OW        = 21
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] in_data [0:N-1],
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          acc_clr,
    output logic [OW-1:0] out_sum,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_sat
);
    localparam int S  = $clog2(N);
    localparam int FW = IW + S + $clog2(ACC_BEATS);
    localparam int CW = (ACC_BEATS > 1) ? $clog2(ACC_BEATS) : 1;

    // Live elements entering level lvl; level lvl+1 element k = element 2k + element 2k+1.
    function automatic int width_at(input int lvl);
        return (N + (1 << lvl) - 1) >> lvl;
    endfunction

    logic signed [FW-1:0] node    [0:S-1][0:N-1];
    logic signed [FW-1:0] stage_d [1:S][0:N-1];
    logic signed [FW-1:0] stage_q [1:S][0:N-1];
    logic [S:1]           stage_vld;
    logic [CW-1:0]        cnt;
    logic signed [FW-1:0] acc;
    logic signed [FW-1:0] tree;
    logic signed [FW-1:0] grp;
    logic                 adv;
    logic                 grp_done;
    logic [OW-1:0]        conv_sum;
    logic                 conv_sat;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    always_comb begin
        int lo;
        int hi;
        lo = 0;
        hi = 0;
        for (int i = 0; i < N; i++) begin
            node[0][i] = FW'($signed(in_data[i]));
        end
        for (int l = 1; l < S; l++) begin
            for (int i = 0; i < N; i++) begin
                node[l][i] = stage_q[l][i];
            end
        end
        for (int l = 0; l < S; l++) begin
            for (int k = 0; k < N; k++) begin
                lo = (2 * k < N) ? 2 * k : N - 1;
                hi = (2 * k + 1 < N) ? 2 * k + 1 : N - 1;
                if (2 * k + 1 < width_at(l)) begin
                    stage_d[l+1][k] = node[l][lo] + node[l][hi];
                end else if (2 * k < width_at(l)) begin
                    stage_d[l+1][k] = node[l][lo];
                end else begin
                    stage_d[l+1][k] = '0;
                end
            end
        end
    end

    assign tree     = stage_q[S][0];
    assign grp      = (cnt == '0) ? tree : acc + tree;
    assign grp_done = stage_vld[S] && !acc_clr && (cnt == CW'(ACC_BEATS - 1));

    generate
        if (OW >= FW) begin : g_extend
            assign conv_sum = OW'(grp);
            assign conv_sat = 1'b0;
        end else begin : g_narrow
`ifdef ADDER_TREE_SAT_EN
            logic ovf;
            assign ovf      = (grp[FW-1:OW-1] != {(FW-OW+1){grp[FW-1]}});
            assign conv_sum = ovf ? {grp[FW-1], {(OW-1){~grp[FW-1]}}} : grp[OW-1:0];
            assign conv_sat = ovf;
`else
            assign conv_sum = grp[OW-1:0];
            assign conv_sat = 1'b0;
`endif
        end
    endgenerate

    // Tree data needs no reset: the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (adv) begin
            stage_q <= stage_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_vld <= '0;
            cnt       <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_sat   <= 1'b0;
        end else if (adv) begin
            // A beat accepted alongside acc_clr survives as beat 0; older beats are dropped.
            stage_vld[1] <= in_valid;
            for (int l = 2; l <= S; l++) begin
                stage_vld[l] <= stage_vld[l-1] && !acc_clr;
            end
            if (acc_clr) begin
                cnt <= '0;
                acc <= '0;
            end else if (stage_vld[S]) begin
                acc <= grp;
                cnt <= grp_done ? '0 : cnt + CW'(1);
            end
            out_valid <= grp_done;
            if (grp_done) begin
                out_sum <= conv_sum;
                out_sat <= conv_sat;
            end
        end
    end
endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Directed bench for pipelined_adder_tree: default instance plus a narrow-output (OW=18) instance.
module tb_pipelined_adder_tree;
    logic        clk = 1'b0;
    logic        rst;
    logic [14:0] in_data [0:11];
    logic        in_valid;
    logic        acc_clr;
    logic        out_ready;
    logic        in_ready, out_valid, out_sat;
    logic [20:0] out_sum;
    logic        in_ready_n, out_valid_n, out_sat_n;
    logic [17:0] out_sum_n;

    int compared   = 0;
    int mismatched = 0;
    int cycle      = 0;
    logic signed [63:0] res_sum [$];
    logic               res_sat [$];
    int                 res_cyc [$];

`ifdef ADDER_TREE_SAT_EN
    localparam logic signed [63:0] EXP_N_SUM = 131071;
    localparam logic signed [63:0] EXP_N_SAT = 1;
`else
    localparam logic signed [63:0] EXP_N_SUM = -48;
    localparam logic signed [63:0] EXP_N_SAT = 0;
`endif

    always #5 clk = ~clk;

    pipelined_adder_tree dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .acc_clr(acc_clr), .out_sum(out_sum), .out_valid(out_valid), .out_ready(out_ready),
        .out_sat(out_sat)
    );

    pipelined_adder_tree #(.OW(18)) dut_n (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_n),
        .acc_clr(acc_clr), .out_sum(out_sum_n), .out_valid(out_valid_n), .out_ready(out_ready),
        .out_sat(out_sat_n)
    );

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [63:0] q_sum(input int i);
        if (i < res_sum.size()) return res_sum[i];
        return 'x;
    endfunction

    function automatic int q_cyc(input int i);
        if (i < res_cyc.size()) return res_cyc[i];
        return -1000;
    endfunction

    task automatic flush_results();
        res_sum.delete();
        res_sat.delete();
        res_cyc.delete();
    endtask

    task automatic drive(input logic v, input int val, input logic clr);
        in_valid = v;
        acc_clr  = clr;
        for (int i = 0; i < 12; i++) in_data[i] = 15'(val);
    endtask

    // One clock: record handshakes on the falling edge, return #1 after the rising edge.
    task automatic tick(output logic took);
        logic signed [63:0] s;
        @(negedge clk);
        took = in_valid && in_ready;
        if (out_valid && out_ready) begin
            s = $signed(out_sum);
            res_sum.push_back(s);
            res_sat.push_back(out_sat);
            res_cyc.push_back(cycle);
        end
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic send(input int val, input logic clr);
        logic took;
        int   n;
        n    = 0;
        took = 1'b0;
        drive(1'b1, val, clr);
        while (!took && n < 20) begin
            tick(took);
            n++;
        end
        if (!took) check("send_timeout", 0, 1);
        drive(1'b0, 0, 1'b0);
    endtask

    task automatic idle(input int n);
        logic took;
        drive(1'b0, 0, 1'b0);
        repeat (n) tick(took);
    endtask

    initial begin
        rst       = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 0, 1'b0);
        #2 rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        idle(1);

        // Ones: 48 appears on the fifth edge after the last beat.
        repeat (4) send(1, 1'b0);
        idle(3);
        check("t1_not_early", out_valid, 0);
        idle(1);
        check("t1_valid", out_valid, 1);
        check("t1_sum", $signed(out_sum), 48);
        idle(2);
        flush_results();

        // Back-to-back groups.
        repeat (4) send(-16384, 1'b0);
        repeat (4) send(1, 1'b0);
        repeat (4) send(2, 1'b0);
        idle(8);
        check("t2_count", res_sum.size(), 3);
        check("t2_sum0", q_sum(0), -786432);
        check("t2_sat0", (res_sat.size() > 0) ? res_sat[0] : 1'bx, 0);
        check("t2_sum1", q_sum(1), 48);
        check("t2_sum2", q_sum(2), 96);
        check("t2_gap01", q_cyc(1) - q_cyc(0), 4);
        check("t2_gap12", q_cyc(2) - q_cyc(1), 4);
        flush_results();

        // Backpressure with a group in flight behind the stalled result.
        repeat (4) send(3, 1'b0);
        repeat (4) send(5, 1'b0);
        check("t3_valid", out_valid, 1);
        out_ready = 1'b0;
        drive(1'b1, 7, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
            cycle++;
            check("t3_hold_valid", out_valid, 1);
            check("t3_hold_sum", $signed(out_sum), 144);
            check("t3_in_ready", in_ready, 0);
        end
        flush_results();
        out_ready = 1'b1;
        repeat (4) send(7, 1'b0);
        idle(10);
        check("t3_count", res_sum.size(), 3);
        check("t3_sum0", q_sum(0), 144);
        check("t3_sum1", q_sum(1), 240);
        check("t3_sum2", q_sum(2), 336);
        flush_results();

        // acc_clr drops the in-flight 100s; its own beat starts the new group.
        repeat (2) send(100, 1'b0);
        send(1, 1'b1);
        repeat (3) send(1, 1'b0);
        idle(10);
        check("t4_count", res_sum.size(), 1);
        check("t4_sum", q_sum(0), 48);
        flush_results();

        // Narrow output: 48 * 16383 = 786384 exceeds 18 bits.
        repeat (4) send(16383, 1'b0);
        idle(4);
        check("t5_n_valid", out_valid_n, 1);
        check("t5_n_sum", $signed(out_sum_n), EXP_N_SUM);
        check("t5_n_sat", out_sat_n, EXP_N_SAT);
        check("t5_wide_sum", $signed(out_sum), 786384);
        check("t5_wide_sat", out_sat, 0);
        idle(2);
        flush_results();

        // Reset mid-group discards the partial group.
        repeat (2) send(2, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        cycle++;
        check("t6_rst_valid", out_valid, 0);
        rst = 1'b0;
        flush_results();
        repeat (4) send(2, 1'b0);
        idle(10);
        check("t6_count", res_sum.size(), 1);
        check("t6_sum", q_sum(0), 96);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
